// File: rtl/fp_mult_pkg.sv
// Shared types, mode encodings and parameter legality check for the
// signed fixed-point multiplier family.
package fp_mult_pkg;

  localparam int ROUND_TRUNC = 0;
  localparam int ROUND_RNE   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit params_ok(input int width, input int int_width,
                                   input int frac_width, input int latency,
                                   input int round_mode);
    return (width == int_width + frac_width) && (frac_width >= 1) &&
           (latency >= 3) && (latency <= 16) &&
           ((round_mode == ROUND_TRUNC) || (round_mode == ROUND_RNE));
  endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Combinational rescale of a full signed product: optional round-to-nearest-even,
// range check, and clamp or wrap into WIDTH bits.
module fp_round_sat
  import fp_mult_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 16,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input  logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   res,
  output logic               ovf
);

  // One spare bit above the shifted product so the rounding increment cannot wrap.
  localparam int RW = 2*WIDTH - FRAC_WIDTH + 1;

  logic          sticky_s;
  logic          guard_s;
  logic          lsb_s;
  logic          inc_s;
  logic [RW-1:0] r_s;
  logic [RW-WIDTH:0] upper_s;

  if (FRAC_WIDTH > 1) begin : g_sticky
    assign sticky_s = |p[FRAC_WIDTH-2:0];
  end else begin : g_no_sticky
    assign sticky_s = 1'b0;
  end

  assign guard_s = p[FRAC_WIDTH-1];
  assign lsb_s   = p[FRAC_WIDTH];

  // Rescale, round, then detect and handle overflow.
  always_comb begin
    inc_s   = 1'b0;
    r_s     = {p[2*WIDTH-1], p[2*WIDTH-1:FRAC_WIDTH]};
    upper_s = '0;
    ovf     = 1'b0;
    res     = '0;
    if (ROUND_MODE == ROUND_RNE) begin
      inc_s = guard_s & (sticky_s | lsb_s);
    end else begin
      inc_s = 1'b0;
    end
    r_s     = r_s + {{(RW-1){1'b0}}, inc_s};
    // In range only when every bit from the result sign upward agrees.
    upper_s = r_s[RW-1:WIDTH-1];
    ovf     = ~((&upper_s) | ~(|upper_s));
    if (ovf && (SATURATE != 0)) begin
      res = r_s[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = r_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/std_fp_smult_rs_pipe.sv
// Pipelined signed fixed-point multiplier with go/done handshake, selectable
// rounding and optional saturation.
module std_fp_smult_rs_pipe
  import fp_mult_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int LATENCY    = 3,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             done
);

  if (!params_ok(WIDTH, INT_WIDTH, FRAC_WIDTH, LATENCY, ROUND_MODE)) begin : g_bad_params
    $error("std_fp_smult_rs_pipe: illegal parameter combination");
  end

  // Product register plus LATENCY-3 delay registers.
  localparam int         PIPE_N   = LATENCY - 2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t               state_r;
  state_t               state_s;
  logic [3:0]           cnt_r;
  logic                 capture_s;
  logic                 finish_s;
  logic [WIDTH-1:0]     left_r;
  logic [WIDTH-1:0]     right_r;
  logic [2*WIDTH-1:0]   left_x_s;
  logic [2*WIDTH-1:0]   right_x_s;
  logic [2*WIDTH-1:0]   pipe_r [PIPE_N];
  logic [WIDTH-1:0]     rs_out_s;
  logic                 rs_ovf_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic; an abort (go low in BUSY) takes priority over expiry.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (go) begin
          capture_s = 1'b1;
          state_s   = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (!go) begin
          state_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          finish_s = 1'b1;
          state_s  = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Cycle counter.
  always_ff @(posedge clk) begin
    if (!reset_n)                                  cnt_r <= 4'd0;
    else if (capture_s)                            cnt_r <= CNT_LOAD;
    else if (state_r == BUSY && cnt_r != 4'd0)     cnt_r <= cnt_r - 4'd1;
    else                                           cnt_r <= cnt_r;
  end

  // Operand registers, loaded only at capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      left_r  <= '0;
      right_r <= '0;
    end else if (capture_s) begin
      left_r  <= left;
      right_r <= right;
    end
  end

  // Sign-extended operands give the exact signed product in the low 2*WIDTH bits.
  assign left_x_s  = {{WIDTH{left_r[WIDTH-1]}}, left_r};
  assign right_x_s = {{WIDTH{right_r[WIDTH-1]}}, right_r};

  // Product and delay registers; operands are stable throughout BUSY.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_N; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= left_x_s * right_x_s;
      for (int i = 1; i < PIPE_N; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  fp_round_sat #(
    .WIDTH      (WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .ROUND_MODE (ROUND_MODE),
    .SATURATE   (SATURATE)
  ) u_round_sat (
    .p   (pipe_r[PIPE_N-1]),
    .res (rs_out_s),
    .ovf (rs_ovf_s)
  );

  // Output register; result and flag move only on completion or reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= finish_s;
      if (finish_s) begin
        out      <= rs_out_s;
        overflow <= rs_ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_std_fp_smult_rs_pipe.sv
// Directed self-checking bench: Q16.16 instances covering truncate, RNE,
// wrap and a LATENCY=7 variant.
module tb_std_fp_smult_rs_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic        go7 = 1'b0;
  logic [31:0] left = 32'd0;
  logic [31:0] right = 32'd0;
  logic [31:0] out_t, out_r, out_w, out_7;
  logic        ovf_t, ovf_r, ovf_w, ovf_7;
  logic        done_t, done_r, done_w, done_7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  std_fp_smult_rs_pipe #(.LATENCY(3), .ROUND_MODE(0), .SATURATE(1)) dut_t (
    .clk(clk), .reset_n(reset_n), .go(go), .left(left), .right(right),
    .out(out_t), .overflow(ovf_t), .done(done_t));
  std_fp_smult_rs_pipe #(.LATENCY(3), .ROUND_MODE(1), .SATURATE(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .go(go), .left(left), .right(right),
    .out(out_r), .overflow(ovf_r), .done(done_r));
  std_fp_smult_rs_pipe #(.LATENCY(3), .ROUND_MODE(0), .SATURATE(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .go(go), .left(left), .right(right),
    .out(out_w), .overflow(ovf_w), .done(done_w));
  std_fp_smult_rs_pipe #(.LATENCY(7), .ROUND_MODE(0), .SATURATE(1)) dut_7 (
    .clk(clk), .reset_n(reset_n), .go(go7), .left(left), .right(right),
    .out(out_7), .overflow(ovf_7), .done(done_7));

  // Start an op on the LATENCY=3 instances; lat = negedges after capture until done (-1 on timeout).
  task automatic run3(input logic [31:0] a, input logic [31:0] b, output int lat);
    int i;
    @(negedge clk);
    left = a; right = b; go = 1'b1;
    lat = -1;
    i = 0;
    while (lat < 0 && i < 20) begin
      @(negedge clk);
      if (done_t) lat = i;
      i++;
    end
    go = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; go = 1'b0; go7 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_t !== 32'd0 || ovf_t !== 1'b0 || done_t !== 1'b0) begin
      errors++; $display("FAIL reset_t out=%h ovf=%b done=%b want 0/0/0", out_t, ovf_t, done_t); end
    checks++; if (out_7 !== 32'd0 || ovf_7 !== 1'b0 || done_7 !== 1'b0) begin
      errors++; $display("FAIL reset_7 out=%h ovf=%b done=%b want 0/0/0", out_7, ovf_7, done_7); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    int i;
    run3(32'h0001_8000, 32'h0002_0000, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
    checks++; if (out_t !== 32'h0003_0000 || ovf_t !== 1'b0) begin
      errors++; $display("FAIL basic_out got %h/%b want 00030000/0", out_t, ovf_t); end
    @(negedge clk);
    checks++; if (done_t !== 1'b0) begin errors++; $display("FAIL basic_single_pulse done=%b want 0", done_t); end
    // Same product on the LATENCY=7 instance.
    left = 32'h0001_8000; right = 32'h0002_0000; go7 = 1'b1;
    lat = -1; i = 0;
    while (lat < 0 && i < 30) begin
      @(negedge clk);
      if (done_7) lat = i;
      i++;
    end
    go7 = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL l7_latency got %0d want 7", lat); end
    checks++; if (out_7 !== 32'h0003_0000 || ovf_7 !== 1'b0) begin
      errors++; $display("FAIL l7_out got %h/%b want 00030000/0", out_7, ovf_7); end
  endtask

  task automatic test_rounding;
    int lat;
    run3(32'h0000_0003, 32'h0000_8000, lat);
    checks++; if (out_t !== 32'h0000_0001) begin errors++; $display("FAIL rnd_pos_trunc got %h want 00000001", out_t); end
    checks++; if (out_r !== 32'h0000_0002) begin errors++; $display("FAIL rnd_pos_rne got %h want 00000002", out_r); end
    run3(32'h0000_0001, 32'h0000_8000, lat);
    checks++; if (out_t !== 32'h0000_0000) begin errors++; $display("FAIL rnd_even_trunc got %h want 00000000", out_t); end
    checks++; if (out_r !== 32'h0000_0000) begin errors++; $display("FAIL rnd_even_rne got %h want 00000000", out_r); end
    run3(32'hFFFF_FFFF, 32'h0000_8000, lat);
    checks++; if (out_t !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rnd_neg_trunc got %h want ffffffff", out_t); end
    checks++; if (out_r !== 32'h0000_0000) begin errors++; $display("FAIL rnd_neg_rne got %h want 00000000", out_r); end
  endtask

  task automatic test_overflow;
    int lat;
    run3(32'h7FFF_0000, 32'h0002_0000, lat);
    checks++; if (out_t !== 32'h7FFF_FFFF || ovf_t !== 1'b1) begin
      errors++; $display("FAIL ovf_pos_sat got %h/%b want 7fffffff/1", out_t, ovf_t); end
    checks++; if (out_w !== 32'hFFFE_0000 || ovf_w !== 1'b1) begin
      errors++; $display("FAIL ovf_pos_wrap got %h/%b want fffe0000/1", out_w, ovf_w); end
    run3(32'h8000_0000, 32'hFFFF_0000, lat);
    checks++; if (out_t !== 32'h7FFF_FFFF || ovf_t !== 1'b1) begin
      errors++; $display("FAIL ovf_minneg_sat got %h/%b want 7fffffff/1", out_t, ovf_t); end
    checks++; if (out_w !== 32'h8000_0000 || ovf_w !== 1'b1) begin
      errors++; $display("FAIL ovf_minneg_wrap got %h/%b want 80000000/1", out_w, ovf_w); end
    run3(32'hFFFF_0000, 32'h0002_0000, lat);
    checks++; if (out_t !== 32'hFFFE_0000 || ovf_t !== 1'b0) begin
      errors++; $display("FAIL neg_in_range got %h/%b want fffe0000/0", out_t, ovf_t); end
  endtask

  task automatic test_abort;
    int lat;
    bit seen;
    run3(32'h0001_8000, 32'h0002_0000, lat);
    checks++; if (out_t !== 32'h0003_0000) begin errors++; $display("FAIL abort_pre got %h want 00030000", out_t); end
    @(negedge clk);
    left = 32'h0002_0000; right = 32'h0002_0000; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_t) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_done got 1 want 0"); end
    checks++; if (out_t !== 32'h0003_0000 || ovf_t !== 1'b0) begin
      errors++; $display("FAIL abort_hold got %h/%b want 00030000/0", out_t, ovf_t); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    run3(32'h7FFF_0000, 32'h0002_0000, lat);
    checks++; if (ovf_t !== 1'b1) begin errors++; $display("FAIL rstmid_pre ovf=%b want 1", ovf_t); end
    @(negedge clk);
    left = 32'h0002_0000; right = 32'h0002_0000; go = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0; go = 1'b0;
    @(negedge clk);
    checks++; if (out_t !== 32'd0 || ovf_t !== 1'b0 || done_t !== 1'b0) begin
      errors++; $display("FAIL rstmid got %h/%b/%b want 00000000/0/0", out_t, ovf_t, done_t); end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_t) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_done got 1 want 0"); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int gap;
    int i;
    @(negedge clk);
    left = 32'h0001_8000; right = 32'h0002_0000; go = 1'b1;
    lat = -1; i = 0;
    while (lat < 0 && i < 20) begin
      @(negedge clk);
      if (done_t) lat = i;
      i++;
    end
    checks++; if (lat !== 3 || out_t !== 32'h0003_0000) begin
      errors++; $display("FAIL b2b_first got lat=%0d out=%h want 3/00030000", lat, out_t); end
    left = 32'h0003_0000;
    gap = -1; i = 1;
    while (gap < 0 && i < 20) begin
      @(negedge clk);
      if (done_t) gap = i;
      i++;
    end
    go = 1'b0;
    checks++; if (gap !== 4) begin errors++; $display("FAIL b2b_gap got %0d want 4", gap); end
    checks++; if (out_t !== 32'h0006_0000 || ovf_t !== 1'b0) begin
      errors++; $display("FAIL b2b_second got %h/%b want 00060000/0", out_t, ovf_t); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
